stream_arb_tree: RTL and testbench

STREAM_ARB_TREE -- requirements
Module: stream_arb_tree

---
 rtl/stream_arb_tree.sv | 166 ++++++++++++++++
 tb/tb_stream_arb_tree.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_arb_tree.sv
// stream_arb_tree
//   Fair round-robin arbiter that merges NumIn valid/ready request streams
//   into one output stream.
//
//   Optional build macro: STREAM_ARB_TREE_OUT_REG_EN
//     undefined : req_o/data_o/idx_o are combinational from req_i/data_i
//                 (zero latency, output handshake == internal handshake).
//     defined   : req_o/data_o/idx_o come from a one-entry output register
//                 (full throughput, one cycle of latency).
//
//   Ports
//     clk_i    : clock, all state on the rising edge
//     rst_i    : asynchronous active-high reset
//     flush_i  : synchronous clear of pointer, lock and output stage
//     req_i    : per-input request
//     gnt_o    : per-input grant, one-hot or zero
//     data_i   : per-input payload
//     req_o    : arbitrated request/valid
//     gnt_i    : downstream grant/ready
//     data_o   : selected payload
//     idx_o    : index of the selected input
module stream_arb_tree #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32,
  parameter bit LockIn    = 1'b1,
  localparam int IdxWidth = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic [NumIn-1:0]                    req_i,
  output logic [NumIn-1:0]                    gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0]     data_i,
  output logic                                req_o,
  input  logic                                gnt_i,
  output logic [DataWidth-1:0]                data_o,
  output logic [IdxWidth-1:0]                 idx_o
);

  // Cyclic increment of an index, wrapping NumIn-1 -> 0.
  function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                   input int unsigned         off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NumIn) s = s - NumIn;
    return s[IdxWidth-1:0];
  endfunction

  logic                 sel_vld;
  logic [IdxWidth-1:0]  sel_idx;
  logic [DataWidth-1:0] sel_data;
  logic                 ready_int;
  logic                 accept;

  logic [IdxWidth-1:0]  rr_q;
  logic                 lock_q;
  logic [IdxWidth-1:0]  lock_idx_q;

  // Stage p0: selection among the current requests
  generate
    if (NumIn == 1) begin : g_single
      assign sel_vld    = req_i[0] & ~rst_i;
      assign sel_idx    = '0;
      assign rr_q       = '0;
      assign lock_q     = 1'b0;
      assign lock_idx_q = '0;
    end else begin : g_rr
      always_comb begin
        logic [IdxWidth-1:0] cand;
        cand    = '0;
        sel_vld = 1'b0;
        sel_idx = '0;
        // A lock only holds while its input still requests; if it drops,
        // the round-robin search below runs in the same cycle.
        if (lock_q && req_i[lock_idx_q]) begin
          sel_vld = 1'b1;
          sel_idx = lock_idx_q;
        end else begin
          for (int unsigned k = 0; k < NumIn; k++) begin
            cand = wrap_add(rr_q, k);
            if (!sel_vld && req_i[cand]) begin
              sel_vld = 1'b1;
              sel_idx = cand;
            end
          end
        end
        // Nothing may be offered or granted while reset is applied.
        if (rst_i) sel_vld = 1'b0;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rr_q       <= '0;
          lock_q     <= 1'b0;
          lock_idx_q <= '0;
        end else if (flush_i) begin
          rr_q       <= '0;
          lock_q     <= 1'b0;
          lock_idx_q <= '0;
        end else if (accept) begin
          rr_q   <= wrap_add(sel_idx, 1);
          lock_q <= 1'b0;
        end else if (sel_vld && LockIn) begin
          lock_q     <= 1'b1;
          lock_idx_q <= sel_idx;
        end else begin
          lock_q <= 1'b0;
        end
      end
    end
  endgenerate

  assign sel_data = data_i[sel_idx];

  // Flush blocks the internal handshake so it wins over a simultaneous accept.
  assign accept = sel_vld & ready_int & ~flush_i;

  always_comb begin
    gnt_o = '0;
    if (accept) gnt_o[sel_idx] = 1'b1;
  end

`ifdef STREAM_ARB_TREE_OUT_REG_EN
  logic                 vld_p1;
  logic [DataWidth-1:0] data_p1;
  logic [IdxWidth-1:0]  idx_p1;

  // The register takes a new item when empty or draining this cycle.
  assign ready_int = ~vld_p1 | gnt_i;

  // Stage p1: one-entry output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
    end else if (flush_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
    end else if (ready_int) begin
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= sel_data;
        idx_p1  <= sel_idx;
      end
    end
  end

  assign req_o  = vld_p1;
  assign data_o = data_p1;
  assign idx_o  = idx_p1;
`else
  assign ready_int = gnt_i;
  // req_o is masked during flush so the downstream never sees a transfer
  // that the upstream side was not granted.
  assign req_o  = sel_vld & ~flush_i;
  assign data_o = sel_vld ? sel_data : '0;
  assign idx_o  = sel_vld ? sel_idx : '0;
`endif

  // A locked input must hold its request until it is granted.
  lock_hold_a : assert property (@(posedge clk_i) disable iff (rst_i)
                                 lock_q |-> req_i[lock_idx_q]);

endmodule

// File: tb/tb_stream_arb_tree.sv
module tb_stream_arb_tree;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef STREAM_ARB_TREE_OUT_REG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_i = 1'b0;
  logic                  flush_i = 1'b0;
  logic [N-1:0]          req_i = '0;
  logic [N-1:0]          gnt_o;
  logic [N-1:0][DW-1:0]  data_i = '0;
  logic                  req_o;
  logic                  gnt_i = 1'b0;
  logic [DW-1:0]         data_o;
  logic [IW-1:0]         idx_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } item_t;
  item_t sbq[$];

  // Reference model state
  int m_rr = 0;
  int m_lidx = 0;
  bit m_lock = 1'b0;
  bit m_vld = 1'b0;

  always #5 clk = ~clk;

  stream_arb_tree #(.NumIn(N), .DataWidth(DW), .LockIn(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .data_i  (data_i),
    .req_o   (req_o),
    .gnt_i   (gnt_i),
    .data_o  (data_o),
    .idx_o   (idx_o)
  );

  function automatic int pick(input logic [N-1:0] r, input int start,
                              input bit lk, input int lidx);
    if (lk && r[lidx]) return lidx;
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // Scoreboard: push on upstream grant, pop on downstream transfer.
  always @(negedge clk) begin : monitor
    int sel;
    bit rdy, acc, ereq, ohs;
    logic [N-1:0] eg;
    item_t it;
    if (rst_i) begin
      n_cmp++;
      if (gnt_o !== '0 || req_o !== 1'b0) begin
        n_err++;
        $display("FAIL mon_reset gnt_o=%b req_o=%b required 0000/0", gnt_o, req_o);
      end
      m_rr = 0; m_lock = 1'b0; m_lidx = 0; m_vld = 1'b0;
      sbq.delete();
    end else begin
      sel  = pick(req_i, m_rr, m_lock, m_lidx);
      rdy  = REG ? (!m_vld || gnt_i) : gnt_i;
      acc  = (sel >= 0) && rdy && !flush_i;
      eg   = '0;
      if (acc) eg[sel] = 1'b1;
      ereq = REG ? m_vld : ((sel >= 0) && !flush_i);
      ohs  = ereq && gnt_i;
      n_cmp++;
      if (gnt_o !== eg) begin
        n_err++;
        $display("FAIL mon_gnt gnt_o=%b required %b", gnt_o, eg);
      end
      n_cmp++;
      if (req_o !== ereq) begin
        n_err++;
        $display("FAIL mon_req req_o=%b required %b", req_o, ereq);
      end
      n_cmp++;
      if (dut.rr_q !== IW'(m_rr)) begin
        n_err++;
        $display("FAIL mon_rr rr_q=%0d required %0d", dut.rr_q, m_rr);
      end
      if (acc) begin
        it.idx  = IW'(sel);
        it.data = data_i[sel];
        sbq.push_back(it);
      end
      if (ohs) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL mon_sb_empty idx_o=%0d data_o=%h with no item expected", idx_o, data_o);
        end else begin
          it = sbq.pop_front();
          if (idx_o !== it.idx || data_o !== it.data) begin
            n_err++;
            $display("FAIL mon_sb_item idx_o=%0d data_o=%h required %0d/%h",
                     idx_o, data_o, it.idx, it.data);
          end
        end
      end
      if (flush_i) begin
        if (REG && m_vld && !ohs && sbq.size() > 0) void'(sbq.pop_front());
        m_rr = 0; m_lock = 1'b0; m_vld = 1'b0;
      end else begin
        if (acc) begin
          m_rr = (sel + 1) % N;
          m_lock = 1'b0;
        end else if (sel >= 0) begin
          m_lock = 1'b1;
          m_lidx = sel;
        end else begin
          m_lock = 1'b0;
        end
        if (REG && rdy) m_vld = acc;
      end
    end
  end

  task automatic tick(input logic [N-1:0] r, input logic g, input logic f);
    @(posedge clk); #1;
    req_i = r; gnt_i = g; flush_i = f;
    @(negedge clk); #1;
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) data_i[i] = base + DW'(i);
  endtask

  task automatic drain();
    tick('0, 1'b1, 1'b0);
    tick('0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    set_data(32'h0A00_0000);
    rst_i = 1'b1; req_i = '1; gnt_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (gnt_o !== '0) begin n_err++; $display("FAIL reset_gnt gnt_o=%b required 0000", gnt_o); end
    n_cmp++;
    if (req_o !== 1'b0) begin n_err++; $display("FAIL reset_req req_o=%b required 0", req_o); end
    n_cmp++;
    if (idx_o !== '0 || data_o !== '0) begin
      n_err++; $display("FAIL reset_out idx_o=%0d data_o=%h required 0/0", idx_o, data_o);
    end
    n_cmp++;
    if (dut.rr_q !== '0) begin n_err++; $display("FAIL reset_rr rr_q=%0d required 0", dut.rr_q); end
    @(posedge clk); #1;
    rst_i = 1'b0; req_i = '0; gnt_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_rr_sequence();
    int ei;
    set_data(32'h1000_0000);
    for (int k = 0; k < 8; k++) begin
      tick(4'b1111, 1'b1, 1'b0);
      n_cmp++;
      if (gnt_o !== 4'(1 << (k % 4))) begin
        n_err++; $display("FAIL rr_seq[%0d] gnt_o=%b required %b", k, gnt_o, 4'(1 << (k % 4)));
      end
      ei = REG ? ((k == 0) ? 0 : (k - 1) % 4) : k % 4;
      n_cmp++;
      if (idx_o !== IW'(ei)) begin
        n_err++; $display("FAIL rr_seq_idx[%0d] idx_o=%0d required %0d", k, idx_o, ei);
      end
    end
    drain();
  endtask

  task automatic test_rr_skip();
    set_data(32'h2000_0000);
    tick(4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0100) begin n_err++; $display("FAIL skip_first gnt_o=%b required 0100", gnt_o); end
    tick(4'b0101, 1'b1, 1'b0);
    n_cmp++;
    if (dut.rr_q !== 2'd3) begin n_err++; $display("FAIL skip_rr3 rr_q=%0d required 3", dut.rr_q); end
    n_cmp++;
    if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL skip_wrap gnt_o=%b required 0001", gnt_o); end
    tick(4'b0100, 1'b1, 1'b0);
    n_cmp++;
    if (dut.rr_q !== 2'd1) begin n_err++; $display("FAIL skip_rr1 rr_q=%0d required 1", dut.rr_q); end
    n_cmp++;
    if (gnt_o !== 4'b0100) begin n_err++; $display("FAIL skip_next gnt_o=%b required 0100", gnt_o); end
    drain();
  endtask

  task automatic test_flush();
    set_data(32'h6000_0000);
    tick(4'b1111, 1'b1, 1'b0);
    tick(4'b1111, 1'b1, 1'b0);
    tick(4'b1111, 1'b1, 1'b1);
    n_cmp++;
    if (gnt_o !== '0) begin n_err++; $display("FAIL flush_gnt gnt_o=%b required 0000", gnt_o); end
    n_cmp++;
    if (dut.rr_q !== 2'd1) begin n_err++; $display("FAIL flush_pre_rr rr_q=%0d required 1", dut.rr_q); end
    tick('0, 1'b0, 1'b0);
    n_cmp++;
    if (dut.rr_q !== '0) begin n_err++; $display("FAIL flush_rr rr_q=%0d required 0", dut.rr_q); end
    n_cmp++;
    if (req_o !== 1'b0) begin n_err++; $display("FAIL flush_req req_o=%b required 0", req_o); end
    tick('0, 1'b1, 1'b0);
  endtask

  task automatic test_lock();
    logic [N-1:0] eg;
    int ei;
    set_data(32'h3000_0000);
    for (int k = 0; k < 3; k++) begin
      tick(4'b0010, 1'b0, 1'b0);
      eg = (REG && k == 0) ? 4'b0010 : 4'b0000;
      ei = (REG && k == 0) ? 0 : 1;
      n_cmp++;
      if (gnt_o !== eg) begin n_err++; $display("FAIL lock_stall[%0d] gnt_o=%b required %b", k, gnt_o, eg); end
      n_cmp++;
      if (idx_o !== IW'(ei)) begin n_err++; $display("FAIL lock_idx[%0d] idx_o=%0d required %0d", k, idx_o, ei); end
    end
    tick(4'b0011, 1'b0, 1'b0);
    n_cmp++;
    if (gnt_o !== '0 || idx_o !== 2'd1) begin
      n_err++; $display("FAIL lock_hold gnt_o=%b idx_o=%0d required 0000/1", gnt_o, idx_o);
    end
    tick(4'b0011, 1'b1, 1'b0);
    n_cmp++;
    if (gnt_o !== 4'b0010) begin n_err++; $display("FAIL lock_grant gnt_o=%b required 0010", gnt_o); end
    tick(4'b0001, 1'b1, 1'b0);
    n_cmp++;
    if (dut.rr_q !== 2'd2) begin n_err++; $display("FAIL lock_rr rr_q=%0d required 2", dut.rr_q); end
    n_cmp++;
    if (gnt_o !== 4'b0001) begin n_err++; $display("FAIL lock_after gnt_o=%b required 0001", gnt_o); end
    drain();
  endtask

  task automatic test_out_reg();
    logic          gseq [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [N-1:0]  gexp [7] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    int            ireg [7] = '{0, 1, 1, 2, 2, 3, 3};
    int            icmb [7] = '{1, 2, 2, 3, 3, 0, 0};
    int ei;
    logic [DW-1:0] ed;
    set_data(32'h4000_0000);
    for (int k = 0; k < 7; k++) begin
      tick(4'b1111, gseq[k], 1'b0);
      ei = REG ? ireg[k] : icmb[k];
      ed = (REG && k == 0) ? 32'h3000_0000 : 32'h4000_0000 + DW'(ei);
      n_cmp++;
      if (gnt_o !== gexp[k]) begin n_err++; $display("FAIL oreg_gnt[%0d] gnt_o=%b required %b", k, gnt_o, gexp[k]); end
      n_cmp++;
      if (idx_o !== IW'(ei) || data_o !== ed) begin
        n_err++; $display("FAIL oreg_out[%0d] idx_o=%0d data_o=%h required %0d/%h", k, idx_o, data_o, ei, ed);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    set_data(32'h5000_0000);
    data_i[2] = 32'hDEADBEEF;
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    n_cmp++;
    if (req_o !== 1'b1 || idx_o !== 2'd2 || data_o !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL stall_out req_o=%b idx_o=%0d data_o=%h required 1/2/deadbeef", req_o, idx_o, data_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if (req_o !== 1'b0 || gnt_o !== '0) begin
      n_err++; $display("FAIL rst_stall_hs req_o=%b gnt_o=%b required 0/0000", req_o, gnt_o);
    end
    n_cmp++;
    if (idx_o !== '0 || data_o !== '0) begin
      n_err++; $display("FAIL rst_stall_out idx_o=%0d data_o=%h required 0/0", idx_o, data_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; req_i = '0;
    @(negedge clk); #1;
    n_cmp++;
    if (dut.rr_q !== '0 || req_o !== 1'b0) begin
      n_err++; $display("FAIL rst_stall_after rr_q=%0d req_o=%b required 0/0", dut.rr_q, req_o);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_rr_sequence();
    test_rr_skip();
    test_flush();
    test_lock();
    test_out_reg();
    test_reset_mid_stall();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_err++; $display("FAIL sb_leftover items=%0d required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
